// File: rtl/genius_pkg.sv
// genius_pkg: shared definitions for the colour-memory game controller.
//   state_e    - controller state encoding
//   LFSR_TAPS  - feedback mask for the 16-bit Fibonacci LFSR (x^16+x^15+x^13+x^4+1)
//   LFSR_SEEDS - four nonzero seeds, selected by REG_SetupMAPA
//   onehot4()  - 2-bit colour index to one-hot LED/button pattern
package genius_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_IN,
    ST_NEXT,
    ST_WIN,
    ST_LOSE
  } state_e;

  localparam int          LFSR_W    = 16;
  // Bits 15,14,12,3 correspond to taps 16,15,13,4.
  localparam logic [15:0] LFSR_TAPS = 16'hD008;
  // Entry [0] is the rightmost element; it doubles as the reset value.
  localparam logic [3:0][LFSR_W-1:0] LFSR_SEEDS = {16'h5A5A, 16'h7F31, 16'h1D2B, 16'hACE1};

  function automatic logic [3:0] onehot4(input logic [1:0] col);
    return 4'b0001 << col;
  endfunction

endpackage

// File: rtl/genius_lfsr.sv
// genius_lfsr: 16-bit maximal-length Fibonacci LFSR.
//   clk, rst : clock, asynchronous active-high reset (state -> seed[0])
//   load     : load 'seed' (has priority over step)
//   step     : advance one position
//   seed     : value loaded on 'load'
//   state    : current LFSR contents
module genius_lfsr
  import genius_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (step) begin
      state_d = {state_q[LFSR_W-2:0], ^(state_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LFSR_SEEDS[0];
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: colour-sequence memory game controller.
//   CLOCK, RESET   : clock, asynchronous active-high reset
//   START          : one-cycle pulse, starts a game from IDLE/WIN/LOSE
//   REG_SetupLEVEL : difficulty 0..3 (display time = SHOW_TICKS >> level)
//   REG_SetupMAPA  : LFSR seed select
//   BTN            : one-hot press pulse, 0 = no press
//   LEDS           : one-hot colour display (4'b1111 in WIN)
//   ROUND, POINTS  : rounds completed, score = (level+1)*ROUND
//   WIN, LOSE, BUSY: terminal flags and game-active flag
// All outputs are registered. LEDS is decoded from the current state, so it
// follows a state change by one clock; the flags are decoded from the next
// state and change on the same edge as the state.
module game_ctrl
  import genius_pkg::*;
#(
  parameter int SHOW_TICKS    = 16,
  parameter int TIMEOUT_TICKS = 64,
  parameter int SEQ_MAX       = 15
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic [1:0] REG_SetupLEVEL,
  input  logic [1:0] REG_SetupMAPA,
  input  logic [3:0] BTN,
  output logic [3:0] LEDS,
  output logic [3:0] ROUND,
  output logic [7:0] POINTS,
  output logic       WIN,
  output logic       LOSE,
  output logic       BUSY
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_TICKS - 1);
  localparam logic [3:0]  LAST_ROUND   = 4'(SEQ_MAX - 1);

  state_e            state_q, state_d;
  logic [1:0]        level_q, level_d;
  logic [1:0]        mapa_q, mapa_d;
  logic [3:0]        round_q, round_d;
  logic [3:0]        idx_q, idx_d;
  logic [7:0]        points_q, points_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [3:0]        leds_q, leds_d;
  logic              win_q, win_d, lose_q, lose_d, busy_q, busy_d;
  logic [15:0][1:0]  seq_q, seq_d;

  logic              start_ok;
  logic              lfsr_load, lfsr_step, lfsr_zero;
  logic [LFSR_W-1:0] lfsr_state, lfsr_seed;
  logic [15:0]       show_raw, show_last;
  logic [3:0]        exp_btn;

  // A zero-length phase (SHOW_TICKS smaller than 2**level) still lasts one clock.
  assign show_raw  = 16'(SHOW_TICKS >> level_q);
  assign show_last = (show_raw == 16'd0) ? 16'd0 : show_raw - 16'd1;
  assign exp_btn   = onehot4(seq_q[idx_q]);

  // Seeds are nonzero and the polynomial is maximal, so zero is unreachable in
  // normal operation; if an upset ever gets it there, reload instead of locking up.
  assign lfsr_zero = (lfsr_state == '0);
  assign lfsr_load = start_ok | lfsr_zero;
  assign lfsr_seed = LFSR_SEEDS[mapa_d];

  genius_lfsr u_lfsr (
    .clk   (CLOCK),
    .rst   (RESET),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (lfsr_seed),
    .state (lfsr_state)
  );

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    mapa_d    = mapa_q;
    round_d   = round_q;
    points_d  = points_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    seq_d     = seq_q;
    leds_d    = 4'd0;
    start_ok  = 1'b0;
    lfsr_step = 1'b0;

    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (state_q == ST_WIN) leds_d = 4'hF;
        if (START) begin
          start_ok = 1'b1;
          level_d  = REG_SetupLEVEL;
          mapa_d   = REG_SetupMAPA;
          round_d  = 4'd0;
          points_d = 8'd0;
          idx_d    = 4'd0;
          cnt_d    = 16'd0;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        seq_d[0]  = lfsr_state[1:0];
        lfsr_step = 1'b1;
        idx_d     = 4'd0;
        cnt_d     = 16'd0;
        state_d   = ST_SHOW_ON;
      end

      ST_SHOW_ON: begin
        leds_d = exp_btn;
        if (cnt_q == show_last) begin
          cnt_d   = 16'd0;
          state_d = ST_SHOW_OFF;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_SHOW_OFF: begin
        if (cnt_q == show_last) begin
          cnt_d = 16'd0;
          if (idx_q < round_q) begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_SHOW_ON;
          end else begin
            idx_d   = 4'd0;
            state_d = ST_WAIT_IN;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_WAIT_IN: begin
        leds_d = BTN;
        if (BTN != 4'd0) begin
          // Exact match required: a multi-bit press never equals a one-hot colour.
          if (BTN == exp_btn) begin
            cnt_d = 16'd0;
            if (idx_q < round_q) idx_d = idx_q + 4'd1;
            else                 state_d = ST_NEXT;
          end else begin
            state_d = ST_LOSE;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_LOSE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_NEXT: begin
        round_d  = round_q + 4'd1;
        points_d = ({6'd0, level_q} + 8'd1) * ({4'd0, round_q} + 8'd1);
        idx_d    = 4'd0;
        cnt_d    = 16'd0;
        if (round_q == LAST_ROUND) begin
          state_d = ST_WIN;
        end else begin
          seq_d[round_q + 4'd1] = lfsr_state[1:0];
          lfsr_step             = 1'b1;
          state_d               = ST_SHOW_ON;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign win_d  = (state_d == ST_WIN);
  assign lose_d = (state_d == ST_LOSE);
  assign busy_d = !(state_d inside {ST_IDLE, ST_WIN, ST_LOSE});

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      level_q  <= 2'd0;
      mapa_q   <= 2'd0;
      round_q  <= 4'd0;
      points_q <= 8'd0;
      idx_q    <= 4'd0;
      cnt_q    <= 16'd0;
      seq_q    <= '0;
      leds_q   <= 4'd0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      mapa_q   <= mapa_d;
      round_q  <= round_d;
      points_q <= points_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      leds_q   <= leds_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
      busy_q   <= busy_d;
    end
  end

  assign LEDS   = leds_q;
  assign ROUND  = round_q;
  assign POINTS = points_q;
  assign WIN    = win_q;
  assign LOSE   = lose_q;
  assign BUSY   = busy_q;

endmodule
